// File: rtl/pipe_pkg.sv
// Shared defaults and field widths for the pipe_track pipeline tracker.
package pipe_pkg;

    localparam int unsigned DATA_W_DEF      = 16;
    localparam int unsigned STAGES_DEF      = 5;
    localparam int unsigned FLUSH_DEPTH_DEF = 2;
    localparam int unsigned OPC_W           = 4;

    localparam logic [OPC_W-1:0] HLT_OPCODE_DEF = 4'hF;

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: valid+data register with hold, bubble-load and kill.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold_i,
    input  logic              bubble_i,
    input  logic              kill_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Kill beats hold, hold beats load; an empty stage always carries zero data.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (kill_i) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (!hold_i) begin
            if (bubble_i) begin
                valid_d = 1'b0;
                data_d  = '0;
            end else begin
                valid_d = valid_i;
                data_d  = data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_track.sv
// In-order pipeline tracker with stall, flush and sticky halt on retirement.
// Optional perf counters (retire_cnt, stall_cnt) enabled by PIPE_TRACK_PERF_CNT_EN.
module pipe_track
    import pipe_pkg::*;
#(
    parameter int unsigned      DATA_W      = DATA_W_DEF,
    parameter int unsigned      STAGES      = STAGES_DEF,
    parameter int unsigned      FLUSH_DEPTH = FLUSH_DEPTH_DEF,
    parameter logic [OPC_W-1:0] HLT_OPCODE  = HLT_OPCODE_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    input  logic [STAGES-1:0]        stall_req,
    input  logic                     flush_req,
    output logic [STAGES-1:0]        stage_valid,
    output logic [STAGES*DATA_W-1:0] stage_data,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     retire,
    output logic                     hlt
`ifdef PIPE_TRACK_PERF_CNT_EN
    ,
    output logic [31:0]              retire_cnt,
    output logic [31:0]              stall_cnt
`endif
);

    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] bubble;
    logic [STAGES-1:0] kill;
    logic [STAGES-1:0] ld_valid;
    logic [STAGES-1:0] valid_s;
    logic [DATA_W-1:0] ld_data [STAGES];
    logic [DATA_W-1:0] data_s  [STAGES];
    logic              opc_match;
    logic              hlt_q, hlt_d;

    // A stall on stage j freezes j and everything younger (lower index).
    always_comb begin
        hold = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            logic acc;
            acc = 1'b0;
            for (int unsigned j = 0; j < STAGES; j++) begin
                if (j >= i) acc = acc | stall_req[j];
            end
            hold[i] = acc;
        end
    end

    always_comb begin
        kill        = '0;
        bubble      = '0;
        ld_valid    = '0;
        ld_valid[0] = in_valid;
        ld_data[0]  = in_data;
        bubble[0]   = ~(in_valid & in_ready);
        for (int unsigned i = 0; i < STAGES; i++) begin
            kill[i] = flush_req & (i < FLUSH_DEPTH);
        end
        for (int unsigned i = 1; i < STAGES; i++) begin
            ld_valid[i] = valid_s[i-1];
            ld_data[i]  = data_s[i-1];
            bubble[i]   = hold[i-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        pipe_stage #(
            .DATA_W(DATA_W)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .hold_i  (hold[g]),
            .bubble_i(bubble[g]),
            .kill_i  (kill[g]),
            .valid_i (ld_valid[g]),
            .data_i  (ld_data[g]),
            .valid_o (valid_s[g]),
            .data_o  (data_s[g])
        );
    end

    always_comb begin
        stage_data = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            stage_data[i*DATA_W +: DATA_W] = data_s[i];
        end
    end

    assign stage_valid = valid_s;
    assign out_valid   = valid_s[STAGES-1];
    assign out_data    = data_s[STAGES-1];
    assign retire      = valid_s[STAGES-1] & ~stall_req[STAGES-1];
    assign opc_match   = (data_s[STAGES-1][DATA_W-1 -: OPC_W] == HLT_OPCODE);
    assign hlt_d       = hlt_q | (retire & opc_match);
    assign hlt         = hlt_d;
    // rst_n gating keeps in_ready low while reset is held, independent of stalls.
    assign in_ready    = rst_n & ~hold[0] & ~hlt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hlt_q <= 1'b0;
        else        hlt_q <= hlt_d;
    end

`ifdef PIPE_TRACK_PERF_CNT_EN
    logic [31:0] retire_cnt_q, retire_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign retire_cnt_d = retire_cnt_q + {31'd0, retire};
    assign stall_cnt_d  = stall_cnt_q + {31'd0, |stall_req};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;
    assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_track.sv
// Directed table-driven bench for pipe_track (default parameters, 5 stages).
module tb_pipe_track;

    localparam int DW = 16;
    localparam int NS = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [DW-1:0]     in_data;
    logic              in_ready;
    logic [NS-1:0]     stall_req;
    logic              flush_req;
    logic [NS-1:0]     stage_valid;
    logic [NS*DW-1:0]  stage_data;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              retire;
    logic              hlt;
`ifdef PIPE_TRACK_PERF_CNT_EN
    logic [31:0]       retire_cnt;
    logic [31:0]       stall_cnt;
`endif

    pipe_track #(
        .DATA_W     (DW),
        .STAGES     (NS),
        .FLUSH_DEPTH(2),
        .HLT_OPCODE (4'hF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .stall_req  (stall_req),
        .flush_req  (flush_req),
        .stage_valid(stage_valid),
        .stage_data (stage_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .retire     (retire),
        .hlt        (hlt)
`ifdef PIPE_TRACK_PERF_CNT_EN
        ,
        .retire_cnt (retire_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic          vld;
        logic [DW-1:0] d;
        logic [NS-1:0] st;
        logic          fl;
        logic          e_rdy;
        logic          e_ret;
        logic [NS-1:0] e_vld;
        logic [DW-1:0] e_s2;
        logic [DW-1:0] e_out;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic vld, input logic [DW-1:0] d, input logic [NS-1:0] st,
                       input logic fl, input logic e_rdy, input logic e_ret,
                       input logic [NS-1:0] e_vld, input logic [DW-1:0] e_s2,
                       input logic [DW-1:0] e_out);
        vq.push_back('{vld, d, st, fl, e_rdy, e_ret, e_vld, e_s2, e_out});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // vld  data      stall     fl  rdy ret valid     s2        out
        add(1, 16'h1001, 5'b00000, 0, 1, 0, 5'b00001, 16'h0000, 16'h0000);
        add(1, 16'h1002, 5'b00000, 0, 1, 0, 5'b00011, 16'h0000, 16'h0000);
        add(1, 16'h1003, 5'b00000, 0, 1, 0, 5'b00111, 16'h1001, 16'h0000);
        add(1, 16'h1004, 5'b00000, 0, 1, 0, 5'b01111, 16'h1002, 16'h0000);
        add(1, 16'h1005, 5'b00000, 0, 1, 0, 5'b11111, 16'h1003, 16'h1001);
        add(0, 16'h0000, 5'b00000, 0, 1, 1, 5'b11110, 16'h1004, 16'h1002);
        add(0, 16'h0000, 5'b00000, 0, 1, 1, 5'b11100, 16'h1005, 16'h1003);
        add(0, 16'h0000, 5'b00000, 0, 1, 1, 5'b11000, 16'h0000, 16'h1004);
        add(0, 16'h0000, 5'b00000, 0, 1, 1, 5'b10000, 16'h0000, 16'h1005);
        add(0, 16'h0000, 5'b00000, 0, 1, 1, 5'b00000, 16'h0000, 16'h0000);
        add(1, 16'h2001, 5'b00000, 0, 1, 0, 5'b00001, 16'h0000, 16'h0000);
        add(1, 16'h2002, 5'b00000, 0, 1, 0, 5'b00011, 16'h0000, 16'h0000);
        add(1, 16'h2003, 5'b00010, 0, 0, 0, 5'b00011, 16'h0000, 16'h0000);
        add(1, 16'h2003, 5'b00000, 0, 1, 0, 5'b00111, 16'h2001, 16'h0000);
        add(1, 16'h2004, 5'b00000, 0, 1, 0, 5'b01111, 16'h2002, 16'h0000);
        add(1, 16'h2005, 5'b00000, 0, 1, 0, 5'b11111, 16'h2003, 16'h2001);
        add(0, 16'h0000, 5'b00000, 1, 1, 1, 5'b11100, 16'h2004, 16'h2002);
        add(0, 16'h0000, 5'b00000, 0, 1, 1, 5'b11000, 16'h0000, 16'h2003);
        add(0, 16'h0000, 5'b00000, 0, 1, 1, 5'b10000, 16'h0000, 16'h2004);
        add(0, 16'h0000, 5'b00000, 0, 1, 1, 5'b00000, 16'h0000, 16'h0000);
        add(1, 16'h3001, 5'b00000, 0, 1, 0, 5'b00001, 16'h0000, 16'h0000);
        add(1, 16'h3002, 5'b00000, 0, 1, 0, 5'b00011, 16'h0000, 16'h0000);
        add(1, 16'h3003, 5'b00000, 0, 1, 0, 5'b00111, 16'h3001, 16'h0000);
        add(1, 16'h3004, 5'b00010, 1, 0, 0, 5'b01000, 16'h0000, 16'h0000);
        add(0, 16'h0000, 5'b00000, 0, 1, 0, 5'b10000, 16'h0000, 16'h3001);
        add(0, 16'h0000, 5'b00000, 0, 1, 1, 5'b00000, 16'h0000, 16'h0000);
        add(1, 16'h4001, 5'b00000, 0, 1, 0, 5'b00001, 16'h0000, 16'h0000);
        add(0, 16'h0000, 5'b00000, 0, 1, 0, 5'b00010, 16'h0000, 16'h0000);
        add(0, 16'h0000, 5'b00000, 0, 1, 0, 5'b00100, 16'h4001, 16'h0000);
        add(0, 16'h0000, 5'b00000, 0, 1, 0, 5'b01000, 16'h0000, 16'h0000);
        add(0, 16'h0000, 5'b00000, 0, 1, 0, 5'b10000, 16'h0000, 16'h4001);
        add(0, 16'h0000, 5'b10000, 0, 0, 0, 5'b10000, 16'h0000, 16'h4001);
        add(0, 16'h0000, 5'b00000, 0, 1, 1, 5'b00000, 16'h0000, 16'h0000);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        stall_req = '0;
        flush_req = 1'b0;
        #12;
        chk("rst stage_valid", stage_valid, 0);
        chk("rst stage_data", stage_data, 0);
        chk("rst in_ready", in_ready, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst retire", retire, 0);
        chk("rst hlt", hlt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[k]) begin
            in_valid  = vq[k].vld;
            in_data   = vq[k].d;
            stall_req = vq[k].st;
            flush_req = vq[k].fl;
            #1;
            chk($sformatf("v%0d in_ready", k), in_ready, vq[k].e_rdy);
            chk($sformatf("v%0d retire", k), retire, vq[k].e_ret);
            chk($sformatf("v%0d hlt", k), hlt, 0);
            step();
            chk($sformatf("v%0d stage_valid", k), stage_valid, vq[k].e_vld);
            chk($sformatf("v%0d stage2_data", k), stage_data[47:32], vq[k].e_s2);
            chk($sformatf("v%0d out_data", k), out_data, vq[k].e_out);
            chk($sformatf("v%0d out_valid", k), out_valid, vq[k].e_vld[NS-1]);
        end
        in_valid  = 1'b0;
        stall_req = '0;
        flush_req = 1'b0;

        // Halt: 0xF000 retires, later words are refused for good.
        in_valid = 1'b1;
        in_data  = 16'hF000;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("halt out_data", out_data, 16'hF000);
        chk("halt retire", retire, 1);
        chk("halt hlt comb", hlt, 1);
        chk("halt in_ready comb", in_ready, 0);
        in_valid = 1'b1;
        in_data  = 16'h1111;
        for (int c = 0; c < 8; c++) begin
            step();
            chk($sformatf("halt c%0d hlt", c), hlt, 1);
            chk($sformatf("halt c%0d in_ready", c), in_ready, 0);
            chk($sformatf("halt c%0d stage_valid", c), stage_valid, 0);
            chk($sformatf("halt c%0d retire", c), retire, 0);
        end

        // Reset mid-stream clears everything asynchronously.
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #2;
        rst_n    = 1'b1;
        chk("post-rst hlt", hlt, 0);
        in_valid = 1'b1;
        for (int w = 0; w < 3; w++) begin
            in_data = 16'h6001 + 16'(w);
            step();
        end
        chk("midrst pre valid", stage_valid, 5'b00111);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst stage_valid", stage_valid, 0);
        chk("midrst stage_data", stage_data, 0);
        chk("midrst out_valid", out_valid, 0);
        chk("midrst retire", retire, 0);
        chk("midrst hlt", hlt, 0);
        chk("midrst in_ready", in_ready, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        in_data = 16'h7001;
        #1;
        chk("rel in_ready", in_ready, 1);
        step();
        chk("rel stage_valid", stage_valid, 5'b00001);
        chk("rel stage0_data", stage_data[15:0], 16'h7001);
        in_valid = 1'b0;

`ifdef PIPE_TRACK_PERF_CNT_EN
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        in_valid = 1'b1;
        for (int w = 0; w < 3; w++) begin
            in_data = 16'h8001 + 16'(w);
            step();
        end
        in_valid  = 1'b0;
        stall_req = 5'b00001;
        repeat (2) step();
        stall_req = '0;
        repeat (8) step();
        chk("cnt retire_cnt", retire_cnt, 32'd3);
        chk("cnt stall_cnt", stall_cnt, 32'd2);
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        chk("cnt preload", retire_cnt, 32'hFFFF_FFFF);
        in_valid = 1'b1;
        in_data  = 16'h9001;
        step();
        in_valid = 1'b0;
        repeat (6) step();
        chk("cnt wrap", retire_cnt, 32'd0);
        chk("cnt stall hold", stall_cnt, 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_track.md
PIPE_TRACK -- requirements
Module: pipe_track

Interface
REQ-001 Parameter DATA_W, default 16: instruction/data word width, legal values 4 or more.
REQ-002 Parameter STAGES, default 5: number of pipeline stages, legal values 2 or more.
REQ-003 Parameter FLUSH_DEPTH, default 2: number of youngest stages killed by flush, legal range 1..STAGES.
REQ-004 Parameter HLT_OPCODE, default 4'hF: halt opcode, compared against word bits [DATA_W-1:DATA_W-4].
REQ-005 clk, input, 1: single clock; all state updates on rising edge.
REQ-006 rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 in_valid, input, 1: fetch word present on in_data.
REQ-008 in_data, input, DATA_W: fetched word.
REQ-009 in_ready, output, 1: stage 0 accepts in_data this cycle.
REQ-010 stall_req, input, STAGES: bit i holds stage i and all younger stages.
REQ-011 flush_req, input, 1: kill stages 0..FLUSH_DEPTH-1 (branch squash).
REQ-012 stage_valid, output, STAGES: valid bit per stage; index 0 is youngest.
REQ-013 stage_data, output, STAGES*DATA_W: stage i word at bits [i*DATA_W +: DATA_W].
REQ-014 out_valid / out_data, output, 1 / DATA_W: last stage contents.
REQ-015 retire, output, 1: last stage valid and not held this cycle.
REQ-016 hlt, output, 1: halt retired or retiring.

Function
REQ-017 hold[i] SHALL equal OR of stall_req[j] for all j >= i.
REQ-018 A held stage SHALL keep its valid bit and data.
REQ-019 An unheld stage i>0 SHALL load from stage i-1; if stage i-1 is held, it loads a bubble (valid=0, data=0).
REQ-020 Stage 0, when unheld, SHALL load in_data with valid=in_valid&in_ready; when in_valid=0 it loads a bubble.
REQ-021 in_ready SHALL equal ~hold[0] & ~hlt.
REQ-022 flush_req SHALL set valid=0 and data=0 on stages 0..FLUSH_DEPTH-1 at the next edge, overriding hold and load.
REQ-023 Stages at index FLUSH_DEPTH and above SHALL be unaffected by flush.
REQ-024 Latency SHALL be STAGES edges from acceptance to out_valid when no stall or flush occurs.
REQ-025 retire SHALL equal stage_valid[STAGES-1] & ~stall_req[STAGES-1].
REQ-026 A sticky hlt_q SHALL set at an edge where retire is high and the opcode equals HLT_OPCODE.
REQ-027 hlt SHALL equal hlt_q | (retire & opcode match).
REQ-028 Once hlt_q is set, no word SHALL be accepted; stages continue draining; only reset clears hlt_q.

Reset
REQ-029 rst_n low SHALL immediately clear all stage valid bits, data, hlt_q and counters to 0.
REQ-030 During reset, in_ready, out_valid, retire and hlt SHALL be 0.
REQ-031 Reset asserted mid-stream SHALL discard all in-flight words; first acceptance is possible at the first edge after release.

Configuration
REQ-032 With PIPE_TRACK_PERF_CNT_EN defined, 32-bit outputs retire_cnt and stall_cnt SHALL exist.
REQ-033 retire_cnt SHALL increment per retire; stall_cnt SHALL increment per cycle with |stall_req; both wrap at 2^32-1 to 0.
REQ-034 Without PIPE_TRACK_PERF_CNT_EN, the counter ports and logic SHALL be absent.

Structure
REQ-035 Shared package pipe_pkg SHALL hold the HLT_OPCODE default, default DATA_W/STAGES/FLUSH_DEPTH, and the opcode-field width constant 4.
REQ-036 Sub-module pipe_stage SHALL implement one stage: valid+data register with hold, bubble-load and kill inputs; it is instantiated STAGES times via generate.

Verification
REQ-037 Stream 0x1001..0x1005 with no stalls -> 0x1001 on out_data at edge 5, then one word per cycle; retire high 5 cycles.
REQ-038 stall_req=5'b00010 for 1 cycle mid-stream -> stages 0-1 hold, stage 2 shows valid=0/data=0x0000, in_ready=0 that cycle, no word lost.
REQ-039 flush_req with FLUSH_DEPTH=2 while stages 0-4 are valid -> stage_valid=5'b11100 next cycle.
REQ-040 Flush and stall_req[1] in the same cycle -> flush wins on stages 0-1; stage 2 receives a bubble.
REQ-041 Issue 0xF000 followed by 0x1111 -> hlt high when 0xF000 retires, stays high; in_ready stays 0; 0x1111 never retires afterwards. Reset mid-stream -> all outputs 0 asynchronously.
REQ-042 With PIPE_TRACK_PERF_CNT_EN: 3 retirements and 2 stall cycles -> retire_cnt=3, stall_cnt=2; preload 32'hFFFFFFFF, then one retire -> retire_cnt wraps to 0.
